// File: rtl/sd_bidir_pio_if.sv
// Avalon-MM slave bus bundle for sd_bidir_pio.
// Signals:
//   address    - 3-bit register select
//   chipselect - slave select
//   write_n    - active-low write strobe
//   writedata  - 32-bit write data (low WIDTH bits used by the port)
//   readdata   - 32-bit registered read data, zero-extended
//   irq        - active-high level interrupt
// The slave modport is used by the PIO; the master modport is for a bus driver.
interface sd_bidir_pio_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );
endinterface

// File: rtl/sd_bidir_pio.sv
// Parametrised bidirectional parallel I/O port on an Avalon-MM bus.
// Every bit has its own output value and direction. Pad inputs pass through
// a synchroniser, feed the DATA read path and an edge detector whose captured
// edges raise a maskable level interrupt.
// Ports:
//   clk        - system clock
//   reset_n    - asynchronous active-low reset
//   bus        - Avalon-MM slave (address, chipselect, write_n, writedata,
//                readdata, irq)
//   bidir_port - WIDTH-bit pad bus, driven where dir=1, Z elsewhere
// Register map: 0 DATA, 1 DIR, 2 IRQMASK, 3 EDGECAP (W1C), 4 OUTSET,
//               5 OUTCLR, 6-7 reserved.
module sd_bidir_pio #(
  parameter int               WIDTH       = 4,
  parameter int               SYNC_STAGES = 2,
  parameter int               EDGE_TYPE   = 0,
  parameter logic [WIDTH-1:0] RESET_OUT   = '0,
  parameter logic [WIDTH-1:0] RESET_DIR   = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  sd_bidir_pio_if.slave    bus,
  inout  wire  [WIDTH-1:0] bidir_port
);

  localparam logic [2:0] A_DATA    = 3'd0;
  localparam logic [2:0] A_DIR     = 3'd1;
  localparam logic [2:0] A_MASK    = 3'd2;
  localparam logic [2:0] A_EDGECAP = 3'd3;
  localparam logic [2:0] A_OUTSET  = 3'd4;
  localparam logic [2:0] A_OUTCLR  = 3'd5;

  localparam int               CNT_W      = 3;
  localparam logic [CNT_W-1:0] PRIME_LAST = CNT_W'(SYNC_STAGES);

  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_dir;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_edgecap;
  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_edge;
  logic [CNT_W-1:0] r_prime_cnt;
  logic             r_primed;
  logic [31:0]      r_readdata;
  logic             r_irq;

  logic             w_wr;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_clr;
  logic [31:0]      w_rdmux;

  function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
    logic [31:0] r;
    r = '0;
    r[WIDTH-1:0] = v;
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] edge_detect(input logic [WIDTH-1:0] s,
                                                   input logic [WIDTH-1:0] p);
    case (EDGE_TYPE)
      0:       return s & ~p;
      1:       return ~s & p;
      default: return s ^ p;
    endcase
  endfunction

  assign w_wr    = bus.chipselect && !bus.write_n;
  assign w_wdata = bus.writedata[WIDTH-1:0];
  assign w_sync  = r_sync[SYNC_STAGES-1];
  assign w_clr   = (w_wr && bus.address == A_EDGECAP) ? w_wdata : '0;

  // Pad drivers: each bit independently driven or released.
  for (genvar i = 0; i < WIDTH; i++) begin : g_pad
    assign bidir_port[i] = r_dir[i] ? r_out[i] : 1'bz;
  end

  // Register writes; only one address per cycle, so no priority between
  // DATA, OUTSET and OUTCLR is needed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out  <= RESET_OUT;
      r_dir  <= RESET_DIR;
      r_mask <= '0;
    end else if (w_wr) begin
      case (bus.address)
        A_DATA:   r_out  <= w_wdata;
        A_DIR:    r_dir  <= w_wdata;
        A_MASK:   r_mask <= w_wdata;
        A_OUTSET: r_out  <= r_out | w_wdata;
        A_OUTCLR: r_out  <= r_out & ~w_wdata;
        default:  ;
      endcase
    end
  end

  // Input synchroniser plus the prev flop used for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
      r_prev <= '0;
    end else begin
      r_sync[0] <= bidir_port;
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
      r_prev <= w_sync;
    end
  end

  // Priming: the synchroniser leaves reset at 0, so a pin already high would
  // look like a rising edge. Detection stays off until the chain and prev
  // have been filled with real pad samples.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prime_cnt <= '0;
      r_primed    <= 1'b0;
    end else if (!r_primed) begin
      if (r_prime_cnt == PRIME_LAST) r_primed    <= 1'b1;
      else                           r_prime_cnt <= r_prime_cnt + CNT_W'(1);
    end
  end

  // Registered edge pulse, then capture. Setting wins over a W1C that hits
  // the same bit in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_edge    <= '0;
      r_edgecap <= '0;
      r_irq     <= 1'b0;
    end else begin
      r_edge    <= r_primed ? edge_detect(w_sync, r_prev) : '0;
      r_edgecap <= (r_edgecap & ~w_clr) | r_edge;
      r_irq     <= |(r_edgecap & r_mask);
    end
  end

  always_comb begin
    w_rdmux = '0;
    case (bus.address)
      A_DATA:    w_rdmux = zext(w_sync);
      A_DIR:     w_rdmux = zext(r_dir);
      A_MASK:    w_rdmux = zext(r_mask);
      A_EDGECAP: w_rdmux = zext(r_edgecap);
      default:   w_rdmux = '0;
    endcase
  end

  // Read data registered every cycle regardless of chipselect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_readdata <= '0;
    else          r_readdata <= w_rdmux;
  end

  assign bus.readdata = r_readdata;
  assign bus.irq      = r_irq;

endmodule
